// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and shared RAM port seen by mem_port_arbiter.
//   slave  : arbiter side (takes fetch/data requests, drives the RAM request)
//   master : environment side (requesters and RAM model)
// Fetch : if_req, if_addr -> if_rdata, if_done, stall_if
// Data  : mem_req, mem_we, mem_addr, mem_wdata -> mem_rdata, mem_done, stall_mem
// RAM   : ram_en, ram_we, ram_addr, ram_wdata -> ram_rdata, ram_ack
interface mem_port_arbiter_if;
  localparam int unsigned DW = 32;

  logic          if_req;
  logic [DW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic          ram_en;
  logic          ram_we;
  logic [DW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          ram_ack;
  logic          stall_if;
  logic          stall_mem;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata, ram_ack,
    output if_rdata, if_done, mem_rdata, mem_done,
    output ram_en, ram_we, ram_addr, ram_wdata, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata, ram_ack,
    input  if_rdata, if_done, mem_rdata, mem_done,
    input  ram_en, ram_we, ram_addr, ram_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port RAM.
// Data normally wins; after STARVE_LIMIT consecutive data grants with fetch
// waiting, fetch is granted. Each access is IDLE -> GRANT_x (until ram_ack) -> DONE.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : mem_port_arbiter_if.slave (fetch, data and RAM signals)
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             ram_en_q, ram_en_d;
  logic             ram_we_q, ram_we_d;
  logic [DW-1:0]    ram_addr_q, ram_addr_d;
  logic [DW-1:0]    ram_wdata_q, ram_wdata_d;
  logic [DW-1:0]    if_rdata_q, if_rdata_d;
  logic [DW-1:0]    mem_rdata_q, mem_rdata_d;
  logic             if_done_q, if_done_d;
  logic             mem_done_q, mem_done_d;
  logic             starving_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    starving_c = bus.if_req && (starve_cnt_q == CNT_W'(STARVE_LIMIT));
    case (state_q)
      IDLE: begin
        if (bus.mem_req && !starving_c) state_d = GRANT_D;
        else if (bus.if_req)            state_d = GRANT_I;
      end
      GRANT_I, GRANT_D: begin
        if (bus.ram_ack) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; request inputs are only sampled on the IDLE grant edge
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    ram_en_d     = 1'b0;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_done_d    = 1'b0;
    mem_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.if_req) starve_cnt_d = '0;
        if (state_d == GRANT_D) begin
          ram_en_d    = 1'b1;
          ram_we_d    = bus.mem_we;
          ram_addr_d  = bus.mem_addr;
          ram_wdata_d = bus.mem_wdata;
          if (bus.if_req && (starve_cnt_q != CNT_W'(STARVE_LIMIT)))
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else if (state_d == GRANT_I) begin
          ram_en_d     = 1'b1;
          ram_we_d     = 1'b0;
          ram_addr_d   = bus.if_addr;
          starve_cnt_d = '0;
        end
      end
      GRANT_I: begin
        if (bus.ram_ack) begin
          if_rdata_d = bus.ram_rdata;
          if_done_d  = 1'b1;
          ram_we_d   = 1'b0;
        end else begin
          ram_en_d = 1'b1;
        end
      end
      GRANT_D: begin
        if (bus.ram_ack) begin
          if (!ram_we_q) mem_rdata_d = bus.ram_rdata;
          mem_done_d = 1'b1;
          ram_we_d   = 1'b0;
        end else begin
          ram_en_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath / output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_done_q    <= 1'b0;
      mem_done_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_done_q    <= if_done_d;
      mem_done_q   <= mem_done_d;
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.mem_done  = mem_done_q;

  // Stalls release in the completion cycle itself
  assign bus.stall_if  = bus.if_req & ~if_done_q;
  assign bus.stall_mem = bus.mem_req & ~mem_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ireq;
    logic        mreq;
    logic        mwe;
    logic [31:0] iaddr;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] rdata;
    int          lat;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_idone;
    logic        exp_mdone;
    logic [31:0] exp_irdata;
    logic [31:0] exp_mrdata;
  } vec_t;

  vec_t vecs [6];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled at the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = 32'h0;
  endtask

  logic        grants [$];
  logic        prev_en;
  logic [31:0] mrd_hold;

  initial begin
    n_checks = 0;
    n_errors = 0;

    //                fetch-only, data read, data write, slow fetch, both, data read
    vecs[0] = '{ireq:1'b1, mreq:1'b0, mwe:1'b0, iaddr:32'h100, maddr:32'h0, mwdata:32'h0,
                rdata:32'hDEADBEEF, lat:2, exp_we:1'b0, exp_addr:32'h100, exp_wdata:32'h0,
                exp_idone:1'b1, exp_mdone:1'b0, exp_irdata:32'hDEADBEEF, exp_mrdata:32'h0};
    vecs[1] = '{ireq:1'b0, mreq:1'b1, mwe:1'b0, iaddr:32'h0, maddr:32'h40, mwdata:32'h0,
                rdata:32'h12345678, lat:1, exp_we:1'b0, exp_addr:32'h40, exp_wdata:32'h0,
                exp_idone:1'b0, exp_mdone:1'b1, exp_irdata:32'hDEADBEEF, exp_mrdata:32'h12345678};
    vecs[2] = '{ireq:1'b0, mreq:1'b1, mwe:1'b1, iaddr:32'h0, maddr:32'h200, mwdata:32'h55,
                rdata:32'hFFFFFFFF, lat:3, exp_we:1'b1, exp_addr:32'h200, exp_wdata:32'h55,
                exp_idone:1'b0, exp_mdone:1'b1, exp_irdata:32'hDEADBEEF, exp_mrdata:32'h12345678};
    vecs[3] = '{ireq:1'b1, mreq:1'b0, mwe:1'b0, iaddr:32'h104, maddr:32'h0, mwdata:32'h0,
                rdata:32'hCAFEF00D, lat:5, exp_we:1'b0, exp_addr:32'h104, exp_wdata:32'h0,
                exp_idone:1'b1, exp_mdone:1'b0, exp_irdata:32'hCAFEF00D, exp_mrdata:32'h12345678};
    vecs[4] = '{ireq:1'b1, mreq:1'b1, mwe:1'b1, iaddr:32'h108, maddr:32'h208, mwdata:32'hA5A5,
                rdata:32'h99999999, lat:1, exp_we:1'b1, exp_addr:32'h208, exp_wdata:32'hA5A5,
                exp_idone:1'b0, exp_mdone:1'b1, exp_irdata:32'hCAFEF00D, exp_mrdata:32'h12345678};
    vecs[5] = '{ireq:1'b0, mreq:1'b1, mwe:1'b0, iaddr:32'h0, maddr:32'h44, mwdata:32'h0,
                rdata:32'h0BADCAFE, lat:2, exp_we:1'b0, exp_addr:32'h44, exp_wdata:32'h0,
                exp_idone:1'b0, exp_mdone:1'b1, exp_irdata:32'hCAFEF00D, exp_mrdata:32'h0BADCAFE};

    // Reset
    reset = 1'b1;
    idle_inputs();
    bus.if_addr   = 32'h0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    step();
    step();
    chk1 ("rst_ram_en",    bus.ram_en,    1'b0);
    chk1 ("rst_ram_we",    bus.ram_we,    1'b0);
    chk32("rst_ram_addr",  bus.ram_addr,  32'h0);
    chk32("rst_ram_wdata", bus.ram_wdata, 32'h0);
    chk32("rst_if_rdata",  bus.if_rdata,  32'h0);
    chk32("rst_mem_rdata", bus.mem_rdata, 32'h0);
    chk1 ("rst_if_done",   bus.if_done,   1'b0);
    chk1 ("rst_mem_done",  bus.mem_done,  1'b0);
    chk1 ("rst_stall_if",  bus.stall_if,  1'b0);
    reset = 1'b0;
    step();

    // Table-driven single transactions
    for (int v = 0; v < 6; v++) begin
      bus.if_req    = vecs[v].ireq;
      bus.if_addr   = vecs[v].iaddr;
      bus.mem_req   = vecs[v].mreq;
      bus.mem_we    = vecs[v].mwe;
      bus.mem_addr  = vecs[v].maddr;
      bus.mem_wdata = vecs[v].mwdata;
      step();
      chk1 ("vec_grant_en",   bus.ram_en,   1'b1);
      chk32("vec_grant_addr", bus.ram_addr, vecs[v].exp_addr);
      chk1 ("vec_grant_we",   bus.ram_we,   vecs[v].exp_we);
      if (vecs[v].exp_we) chk32("vec_grant_wdata", bus.ram_wdata, vecs[v].exp_wdata);
      chk1 ("vec_grant_stall_if",  bus.stall_if,  vecs[v].ireq);
      chk1 ("vec_grant_stall_mem", bus.stall_mem, vecs[v].mreq);
      for (int k = 1; k < vecs[v].lat; k++) begin
        step();
        chk1("vec_wait_en",    bus.ram_en,   1'b1);
        chk1("vec_wait_idone", bus.if_done,  1'b0);
        chk1("vec_wait_mdone", bus.mem_done, 1'b0);
      end
      bus.ram_ack   = 1'b1;
      bus.ram_rdata = vecs[v].rdata;
      step();
      bus.ram_ack   = 1'b0;
      bus.ram_rdata = 32'h5A5A5A5A;
      chk1 ("vec_done_en",     bus.ram_en,    1'b0);
      chk1 ("vec_done_idone",  bus.if_done,   vecs[v].exp_idone);
      chk1 ("vec_done_mdone",  bus.mem_done,  vecs[v].exp_mdone);
      chk32("vec_done_irdata", bus.if_rdata,  vecs[v].exp_irdata);
      chk32("vec_done_mrdata", bus.mem_rdata, vecs[v].exp_mrdata);
      chk1 ("vec_done_stall_if",  bus.stall_if,  vecs[v].ireq & ~vecs[v].exp_idone);
      chk1 ("vec_done_stall_mem", bus.stall_mem, vecs[v].mreq & ~vecs[v].exp_mdone);
      idle_inputs();
      step();
      chk1 ("vec_after_en",     bus.ram_en,    1'b0);
      chk1 ("vec_after_idone",  bus.if_done,   1'b0);
      chk1 ("vec_after_mdone",  bus.mem_done,  1'b0);
      chk32("vec_after_irdata", bus.if_rdata,  vecs[v].exp_irdata);
      chk32("vec_after_mrdata", bus.mem_rdata, vecs[v].exp_mrdata);
    end
    mrd_hold = 32'h0BADCAFE;

    // Simultaneous requests: data write first, then the waiting fetch
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h10C;
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 32'h200;
    bus.mem_wdata = 32'h55;
    step();
    chk1 ("sim_d_we",    bus.ram_we,    1'b1);
    chk32("sim_d_addr",  bus.ram_addr,  32'h200);
    chk32("sim_d_wdata", bus.ram_wdata, 32'h55);
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h77777777;
    step();
    bus.ram_ack   = 1'b0;
    chk1 ("sim_d_mdone",  bus.mem_done,  1'b1);
    chk1 ("sim_d_idone",  bus.if_done,   1'b0);
    chk32("sim_d_mrdata", bus.mem_rdata, mrd_hold);
    bus.mem_req = 1'b0;
    step();
    chk1("sim_gap_en", bus.ram_en, 1'b0);
    step();
    chk1 ("sim_i_en",   bus.ram_en,   1'b1);
    chk1 ("sim_i_we",   bus.ram_we,   1'b0);
    chk32("sim_i_addr", bus.ram_addr, 32'h10C);
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h11112222;
    step();
    bus.ram_ack   = 1'b0;
    chk1 ("sim_i_idone",  bus.if_done,   1'b1);
    chk32("sim_i_irdata", bus.if_rdata,  32'h11112222);
    chk32("sim_i_mrdata", bus.mem_rdata, mrd_hold);
    idle_inputs();
    step();
    step();

    // Starvation: both held, ack always high; expect 4 data grants then 1 fetch
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h500;
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'h300;
    bus.ram_ack  = 1'b1;
    bus.ram_rdata = 32'h0;
    prev_en = 1'b0;
    grants.delete();
    for (int c = 0; c < 30; c++) begin
      step();
      if (prev_en) chk1("starve_en_gap", bus.ram_en, 1'b0);
      if (bus.ram_en) grants.push_back(bus.ram_addr == 32'h500);
      prev_en = bus.ram_en;
    end
    idle_inputs();
    chk32("starve_grant_count", 32'(grants.size()), 32'd10);
    for (int g = 0; g < grants.size() && g < 10; g++)
      chk1($sformatf("starve_grant%0d_is_fetch", g), grants[g], (g % 5) == 4);
    step();
    step();

    // Data address changes mid-grant are ignored
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'h300;
    step();
    chk32("chg_addr0", bus.ram_addr, 32'h300);
    bus.mem_addr = 32'h304;
    for (int k = 0; k < 2; k++) begin
      step();
      chk1 ("chg_en",   bus.ram_en,   1'b1);
      chk32("chg_addr", bus.ram_addr, 32'h300);
    end
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h00003030;
    step();
    bus.ram_ack = 1'b0;
    chk1 ("chg_mdone",     bus.mem_done,  1'b1);
    chk32("chg_mrdata",    bus.mem_rdata, 32'h00003030);
    chk32("chg_done_addr", bus.ram_addr,  32'h300);
    idle_inputs();
    step();

    // Reset during a fetch grant, with the request still asserted
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h600;
    step();
    chk1("rmid_grant_en", bus.ram_en, 1'b1);
    step();
    reset = 1'b1;
    step();
    chk1 ("rmid_en",     bus.ram_en,    1'b0);
    chk1 ("rmid_we",     bus.ram_we,    1'b0);
    chk1 ("rmid_idone",  bus.if_done,   1'b0);
    chk32("rmid_addr",   bus.ram_addr,  32'h0);
    chk32("rmid_irdata", bus.if_rdata,  32'h0);
    chk32("rmid_mrdata", bus.mem_rdata, 32'h0);
    reset         = 1'b0;
    bus.if_req    = 1'b0;
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h00000BAD;
    for (int k = 0; k < 3; k++) begin
      step();
      chk1 ("stray_en",     bus.ram_en,   1'b0);
      chk1 ("stray_idone",  bus.if_done,  1'b0);
      chk1 ("stray_mdone",  bus.mem_done, 1'b0);
      chk32("stray_irdata", bus.if_rdata, 32'h0);
    end
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive data grants while fetch waits.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 if_req  in  1  instruction fetch read request; held until if_done.
REQ-005 if_addr  in  32  fetch address.
REQ-006 if_rdata  out  32  registered fetch read data, valid when if_done=1.
REQ-007 if_done  out  1  one-cycle fetch completion pulse.
REQ-008 mem_req  in  1  data access request; held until mem_done.
REQ-009 mem_we  in  1  data write enable (1 = write, 0 = read).
REQ-010 mem_addr  in  32  data address.
REQ-011 mem_wdata  in  32  data write value.
REQ-012 mem_rdata  out  32  registered data read value, valid when mem_done=1 and access was a read.
REQ-013 mem_done  out  1  one-cycle data completion pulse.
REQ-014 ram_en  out  1  shared single-port RAM request.
REQ-015 ram_we  out  1  RAM write enable.
REQ-016 ram_addr  out  32  RAM address.
REQ-017 ram_wdata  out  32  RAM write data.
REQ-018 ram_rdata  in  32  RAM read data, valid with ram_ack.
REQ-019 ram_ack  in  1  RAM completion, variable latency >= 1 cycle after ram_en rises.
REQ-020 stall_if  out  1  fetch stage stall (combinational).
REQ-021 stall_mem  out  1  memory stage stall (combinational).

Function
REQ-022 FSM states IDLE, GRANT_I, GRANT_D, DONE; one state per cycle.
REQ-023 IDLE: mem_req=1 and not starving -> GRANT_D; else if_req=1 -> GRANT_I; else stay IDLE.
REQ-024 Starving = if_req=1 and starve_cnt == STARVE_LIMIT; then both requests present -> GRANT_I.
REQ-025 starve_cnt (width ceil(log2(STARVE_LIMIT+1))) increments on each GRANT_D entry with if_req=1, saturates at STARVE_LIMIT, clears on GRANT_I entry or on IDLE arbitration with if_req=0.
REQ-026 On grant edge, address, we (0 for fetch), wdata latched; requester input changes during GRANT/DONE ignored.
REQ-027 GRANT_x: ram_en=1, ram_addr/ram_we/ram_wdata from latched copies; ram_we=0 in GRANT_I; hold until ram_ack=1.
REQ-028 GRANT_x with ram_ack=1 -> DONE; read data captured into if_rdata (GRANT_I) or mem_rdata (GRANT_D read) on that edge.
REQ-029 Data write: mem_rdata retains its previous value.
REQ-030 DONE: exactly one of if_done/mem_done =1 per granted requester, ram_en=0, no arbitration; next state IDLE.
REQ-031 Minimum access = 3 cycles (IDLE arbitrate, GRANT with ack, DONE); ram_en never high two accesses back-to-back without an intervening low cycle.
REQ-032 ram_ack outside GRANT_I/GRANT_D ignored.
REQ-033 stall_if = if_req & ~if_done; stall_mem = mem_req & ~mem_done.
REQ-034 if_rdata/mem_rdata hold value between completions.

Reset
REQ-035 reset=1 at an edge: state IDLE, starve_cnt 0, ram_en/ram_we/if_done/mem_done 0, ram_addr/ram_wdata/if_rdata/mem_rdata 0.
REQ-036 Reset mid-GRANT abandons access: ram_en low in cycle after reset edge, no done pulse, later ram_ack ignored.
REQ-037 Reset priority over all other inputs in the same cycle.

Verification
REQ-038 Fetch only: if_req=1, if_addr=0x100, ram_ack 2 cycles later with ram_rdata=0xDEADBEEF -> ram_addr=0x100, ram_we=0, if_done one cycle, if_rdata=0xDEADBEEF, stall_if low only in done cycle.
REQ-039 Simultaneous: if_req=1 and mem_req=1 (write 0x200 <- 0x55) -> GRANT_D first (ram_we=1, ram_wdata=0x55), then GRANT_I; mem_rdata unchanged.
REQ-040 Starvation, STARVE_LIMIT=4: mem_req and if_req held continuously, ram_ack=1 each grant cycle -> exactly 4 data grants then 1 fetch grant, repeating.
REQ-041 Input change: mem_addr switched 0x300->0x304 during GRANT_D -> ram_addr stays 0x300 until DONE.
REQ-042 Reset mid-access: reset during GRANT_I before ram_ack -> next cycle ram_en=0, no if_done, stray ram_ack ignored, outputs at reset values.
REQ-043 Ack latency 1 vs 5 cycles -> done asserted exactly one cycle after ram_ack each time; ram_en high continuously through waiting.
